// File: rtl/branch_resolve.sv
// Branch resolution stage: carries D-stage branches through E/M, detects
// mispredictions in M, requests a one-shot flush and keeps saturating counters.
module branch_resolve #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic                 stallM,
  input  logic                 flushM,
  input  logic                 branchD,
  input  logic                 pred_takeD,
  input  logic [31:0]          pcD,
  input  logic [31:0]          targetD,
  input  logic                 actual_takeM,
  output logic                 branchM,
  output logic [31:0]          pcM,
  output logic                 flush_reqM,
  output logic [31:0]          redirect_pcM,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int unsigned XLEN = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [XLEN-1:0] FALL_THRU_OFS = XLEN'(8);

  logic                 br_e_q, br_e_d;
  logic                 pred_e_q, pred_e_d;
  logic [XLEN-1:0]      pc_e_q, pc_e_d;
  logic [XLEN-1:0]      tgt_e_q, tgt_e_d;
  logic                 br_m_q, br_m_d;
  logic                 pred_m_q, pred_m_d;
  logic [XLEN-1:0]      pc_m_q, pc_m_d;
  logic [XLEN-1:0]      tgt_m_q, tgt_m_d;
  logic                 reported_m_q, reported_m_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
  logic                 mispred_m;

  // Resolution in M: flush only once per branch even if M is held
  always_comb begin
    mispred_m    = br_m_q & (pred_m_q ^ actual_takeM);
    flush_reqM   = mispred_m & ~reported_m_q;
    redirect_pcM = '0;
    if (br_m_q) begin
      redirect_pcM = actual_takeM ? tgt_m_q : pc_m_q + FALL_THRU_OFS;
    end
  end

  // D->E register
  always_comb begin
    br_e_d   = br_e_q;
    pred_e_d = pred_e_q;
    pc_e_d   = pc_e_q;
    tgt_e_d  = tgt_e_q;
    if (flushE) begin
      br_e_d   = 1'b0;
      pred_e_d = 1'b0;
      pc_e_d   = '0;
      tgt_e_d  = '0;
    end else if (!stallE) begin
      br_e_d   = branchD;
      pred_e_d = pred_takeD;
      pc_e_d   = pcD;
      tgt_e_d  = targetD;
    end
  end

  // E->M register; a stalled E feeds a bubble into a moving M
  always_comb begin
    br_m_d       = br_m_q;
    pred_m_d     = pred_m_q;
    pc_m_d       = pc_m_q;
    tgt_m_d      = tgt_m_q;
    reported_m_d = reported_m_q;
    if (flushM) begin
      br_m_d       = 1'b0;
      reported_m_d = 1'b0;
    end else if (!stallM) begin
      br_m_d       = br_e_q & ~stallE;
      pred_m_d     = pred_e_q;
      pc_m_d       = pc_e_q;
      tgt_m_d      = tgt_e_q;
      reported_m_d = 1'b0;
    end else begin
      reported_m_d = reported_m_q | flush_reqM;
    end
  end

  // Saturating counters advance when a branch leaves M
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (br_m_q && !stallM) begin
      if (branch_cnt_q != CNT_MAX) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (mispred_m && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_e_q        <= 1'b0;
      pred_e_q      <= 1'b0;
      pc_e_q        <= '0;
      tgt_e_q       <= '0;
      br_m_q        <= 1'b0;
      pred_m_q      <= 1'b0;
      pc_m_q        <= '0;
      tgt_m_q       <= '0;
      reported_m_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_e_q        <= br_e_d;
      pred_e_q      <= pred_e_d;
      pc_e_q        <= pc_e_d;
      tgt_e_q       <= tgt_e_d;
      br_m_q        <= br_m_d;
      pred_m_q      <= pred_m_d;
      pc_m_q        <= pc_m_d;
      tgt_m_q       <= tgt_m_d;
      reported_m_q  <= reported_m_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchM     = br_m_q;
  assign pcM         = pc_m_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
